// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the RV32I datapath: walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB and traps on illegal opcodes or memory timeout.
module mc_sequencer #(
    parameter int WAIT_MAX = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [3:0]       zcnv,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ir_load,
    output logic [5:0]       ctrl_wrd,
    output logic             illegal_instr,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retired
);
    localparam int WC_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t            state_reg, state_next;
    logic [WC_W-1:0]   wait_cnt_reg;
    logic [CNT_W-1:0]  retired_reg;
    logic              illegal_reg, timeout_reg;

    logic is_r, is_i, is_load, is_store, is_branch, branch_taken;
    logic s_pc_sel, s_alub_sel, s_wb_sel, reg_we, dmem_re, dmem_we;
    logic pc_en_next, ir_load_next;
    logic retire, set_illegal, set_timeout, clear_wait, inc_wait;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);

    // zcnv = {Z, C, N, V}; C set means no borrow, so unsigned-less-than is !C
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zcnv[3];
            3'b001:  branch_taken = !zcnv[3];
            3'b100:  branch_taken = zcnv[1] ^ zcnv[0];
            3'b101:  branch_taken = !(zcnv[1] ^ zcnv[0]);
            3'b110:  branch_taken = !zcnv[2];
            3'b111:  branch_taken = zcnv[2];
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        pc_en_next   = 1'b0;
        ir_load_next = 1'b0;
        s_pc_sel     = 1'b0;
        s_alub_sel   = 1'b0;
        s_wb_sel     = 1'b0;
        reg_we       = 1'b0;
        dmem_re      = 1'b0;
        dmem_we      = 1'b0;
        retire       = 1'b0;
        set_illegal  = 1'b0;
        set_timeout  = 1'b0;
        clear_wait   = 1'b0;
        inc_wait     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_load_next = 1'b1;
                state_next   = S_DECODE;
            end
            S_DECODE: begin
                if (!(is_r || is_i || is_load || is_store || is_branch) ||
                    (is_branch && (funct3 == 3'b010 || funct3 == 3'b011))) begin
                    set_illegal = 1'b1;
                    state_next  = S_TRAP;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                s_alub_sel = is_i || is_load || is_store;
                if (is_branch) begin
                    pc_en_next = 1'b1;
                    s_pc_sel   = branch_taken;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (is_load || is_store) begin
                    clear_wait = 1'b1;
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                s_alub_sel = 1'b1;
                dmem_re    = is_load;
                dmem_we    = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_en_next = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    set_timeout = 1'b1;
                    state_next  = S_TRAP;
                end else begin
                    inc_wait = 1'b1;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                s_wb_sel   = is_load;
                s_alub_sel = is_i || is_load || is_store;
                pc_en_next = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            retired_reg  <= '0;
            illegal_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (clear_wait)
                wait_cnt_reg <= '0;
            else if (inc_wait)
                wait_cnt_reg <= wait_cnt_reg + WC_W'(1);
            if (retire)
                retired_reg <= retired_reg + CNT_W'(1);
            if (set_illegal)
                illegal_reg <= 1'b1;
            if (set_timeout)
                timeout_reg <= 1'b1;
        end
    end

    // Reset masks the strobes so an abandoned instruction cannot write anything
    assign pc_en         = pc_en_next && !rst;
    assign ir_load       = ir_load_next && !rst;
    assign ctrl_wrd      = rst ? 6'b0 : {s_pc_sel, s_alub_sel, s_wb_sel, reg_we, dmem_re, dmem_we};
    assign illegal_instr = illegal_reg;
    assign mem_timeout   = timeout_reg;
    assign retired       = retired_reg;
endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle control sequencer for the RV32I core datapath. Replaces single-cycle control-word generation.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives PC enable, instruction-register load and the six-bit datapath control word.
- Waits on a data-memory ready handshake, evaluates branch conditions from the ALU ZCNV flags, and traps on illegal opcodes or memory timeout.

Parameters:
- WAIT_MAX, 8: maximum MEM-state cycles without mem_ready before timeout trap.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- opcode  input  7  instruction bits [6:0], from the instruction register output.
- funct3  input  3  instruction bits [14:12].
- zcnv  input  4  ALU flags {Z,C,N,V}; C=1 means no borrow on subtract.
- mem_ready  input  1  data memory has completed the current read or write.
- pc_en  output  1  PC register load enable.
- ir_load  output  1  instruction register load enable.
- ctrl_wrd  output  6  {s_pc_sel, s_alub_sel, s_wb_sel, reg_we, dmem_re, dmem_we}.
- illegal_instr  output  1  sticky flag: unsupported opcode or funct3.
- mem_timeout  output  1  sticky flag: data-memory handshake exceeded WAIT_MAX.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset is synchronous, active-high on clk. On reset: state=FETCH, wait counter=0, retired=0, illegal_instr=0, mem_timeout=0.
- While rst=1, pc_en, ir_load and ctrl_wrd are forced to 0. The first FETCH cycle is the first clock after rst deasserts.
- Control outputs are a combinational function of: the state register, opcode/funct3 (held stable by the IR after FETCH), and zcnv (used in EXEC only). Every output not listed for a state is 0.
- Supported opcodes:
  - R 0110011 (R-type ALU)
  - I 0010011 (I-type ALU)
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011
- FETCH: ir_load=1. Next state DECODE.
- DECODE: unsupported opcode, or BRANCH with funct3=010/011 -> TRAP with illegal_instr set. Otherwise -> EXEC.
- EXEC:
  - s_alub_sel=1 for I, LOAD and STORE; 0 for R and BRANCH.
  - R or I -> WB. LOAD or STORE -> MEM (wait counter cleared).
  - BRANCH: pc_en=1, s_pc_sel=taken, next state FETCH, retired increments.
  - Taken conditions by funct3:
    - 000 BEQ: Z
    - 001 BNE: !Z
    - 100 BLT: N^V
    - 101 BGE: !(N^V)
    - 110 BLTU: !C
    - 111 BGEU: C
- MEM:
  - s_alub_sel=1. dmem_re=1 (LOAD) or dmem_we=1 (STORE), held every cycle until mem_ready.
  - mem_ready=1 in the same cycle:
    - STORE: pc_en=1, s_pc_sel=0, retired++, next state FETCH.
    - LOAD: next state WB.
  - mem_ready=0: wait counter increments. When the counter equals WAIT_MAX-1 and mem_ready=0 in that cycle -> TRAP with mem_timeout set. A ready arriving in that same cycle wins (no timeout).
- WB:
  - reg_we=1. s_wb_sel=1 for LOAD, 0 for R/I. s_alub_sel as in EXEC.
  - pc_en=1, s_pc_sel=0, retired++. Next state FETCH.
- TRAP:
  - All control outputs 0 and flags held.
  - Remains in TRAP until rst.
- Latency in cycles:
  - R/I: 4.
  - BRANCH: 3.
  - STORE: 4 + wait cycles.
  - LOAD: 5 + wait cycles.
- retired wraps modulo 2^CNT_W with no saturation or flag.
- Reset mid-instruction abandons it: no increment, no write enable, and the next cycle restarts at FETCH.
- mem_ready is ignored outside MEM.
- opcode and funct3 changes outside FETCH are not expected. The block samples them combinationally.
- illegal_instr and mem_timeout are never both set.

Test Plan:
- R-type: rst high 2 cycles, opcode=0110011 -> ir_load in cycle 1. Cycle 4 shows reg_we=1, s_wb_sel=0, pc_en=1. retired=1 after cycle 4; back to FETCH in cycle 5.
- LOAD, mem_ready after 3 wait cycles -> dmem_re=1 for 4 consecutive cycles. Next WB cycle has reg_we=1 and s_wb_sel=1. Total 8 cycles; retired increments once.
- BEQ: zcnv=4'b1000 -> EXEC shows pc_en=1, s_pc_sel=1. Repeat with BLTU, zcnv=4'b0100 (C=1) -> s_pc_sel=0. Each takes 3 cycles.
- STORE, mem_ready never asserted, WAIT_MAX=8 -> dmem_we high for 8 cycles, then TRAP with mem_timeout=1. All outputs 0 thereafter; retired unchanged; rst clears the flag.
- opcode=1101111, and separately BRANCH with funct3=010 -> illegal_instr=1 after DECODE. No pc_en, reg_we or dmem_* ever asserted.
- Mid-operation reset: rst in a LOAD MEM cycle with mem_ready=1 -> no WB, retired unchanged. With CNT_W=4, 16 R-type retirements -> retired wraps 15->0.
